// File: rtl/loop_jump_sequencer.sv
// Loop-control engine: issues one body iteration per handshake, resolves
// break / continue / disable jumps reported by the body, accumulates the
// per-iteration results and reports how the loop exited.
module loop_jump_sequencer #(
  parameter int IDX_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  loop_count,
  input  logic [1:0]        loop_mode,
  input  logic              abort,
  output logic              body_valid,
  output logic [IDX_W-1:0]  body_idx,
  input  logic              body_ready,
  input  logic [DATA_W-1:0] body_result,
  input  logic              jmp_break,
  input  logic              jmp_continue,
  input  logic              jmp_disable,
  output logic              busy,
  output logic              done,
  output logic [1:0]        exit_code,
  output logic [IDX_W-1:0]  iter_count,
  output logic [DATA_W-1:0] acc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] EXIT_NORMAL   = 2'd0;
  localparam logic [1:0] EXIT_BREAK    = 2'd1;
  localparam logic [1:0] EXIT_DISABLE  = 2'd2;
  localparam logic [1:0] EXIT_EMPTY    = 2'd3;
  localparam logic [1:0] MODE_DO_WHILE = 2'd2;

  state_t             state, state_n;
  logic [IDX_W-1:0]   bound, bound_n;
  logic [IDX_W-1:0]   idx_n;
  logic [IDX_W-1:0]   iter_n;
  logic [DATA_W-1:0]  acc_n;
  logic [1:0]         exit_n;
  logic [IDX_W:0]     idx_inc;
  logic               last_iter;

  // One extra bit so idx+1 never wraps before comparing against the bound.
  assign idx_inc   = {1'b0, body_idx} + (IDX_W+1)'(1);
  assign last_iter = idx_inc >= {1'b0, bound};

  assign body_valid = (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // Next-state and datapath update decisions.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_n = state;
    bound_n = bound;
    idx_n   = body_idx;
    iter_n  = iter_count;
    acc_n   = acc;
    exit_n  = exit_code;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          acc_n  = '0;
          iter_n = '0;
          idx_n  = '0;
          exit_n = EXIT_NORMAL;
          if (loop_count == '0 && loop_mode != MODE_DO_WHILE) begin
            state_n = S_DONE;
            exit_n  = EXIT_EMPTY;
            bound_n = '0;
          end else begin
            state_n = S_RUN;
            // Do-while with a zero count still runs its body once.
            bound_n = (loop_count == '0) ? IDX_W'(1) : loop_count;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // External disable wins over a same-cycle handshake.
          state_n = S_DONE;
          exit_n  = EXIT_DISABLE;
        end else if (body_ready) begin
          iter_n = iter_count + IDX_W'(1);
          if (jmp_disable) begin
            state_n = S_DONE;
            exit_n  = EXIT_DISABLE;
          end else if (jmp_break) begin
            state_n = S_DONE;
            exit_n  = EXIT_BREAK;
          end else begin
            if (!jmp_continue) acc_n = acc + body_result;
            if (last_iter) begin
              state_n = S_DONE;
              exit_n  = EXIT_NORMAL;
            end else begin
              idx_n = idx_inc[IDX_W-1:0];
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    if (rst) begin
      state      <= S_IDLE;
      bound      <= '0;
      body_idx   <= '0;
      iter_count <= '0;
      acc        <= '0;
      exit_code  <= EXIT_NORMAL;
    end else begin
      state      <= state_n;
      bound      <= bound_n;
      body_idx   <= idx_n;
      iter_count <= iter_n;
      acc        <= acc_n;
      exit_code  <= exit_n;
    end
  end

endmodule

// File: tb/tb_loop_jump_sequencer.sv
// Directed self-checking bench for loop_jump_sequencer.
module tb_loop_jump_sequencer;

  localparam int IDX_W  = 8;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  loop_count;
  logic [1:0]        loop_mode;
  logic              abort;
  logic              body_valid;
  logic [IDX_W-1:0]  body_idx;
  logic              body_ready;
  logic [DATA_W-1:0] body_result;
  logic              jmp_break;
  logic              jmp_continue;
  logic              jmp_disable;
  logic              busy;
  logic              done;
  logic [1:0]        exit_code;
  logic [IDX_W-1:0]  iter_count;
  logic [DATA_W-1:0] acc;

  int checks = 0;
  int errors = 0;

  loop_jump_sequencer #(.IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .loop_count   (loop_count),
    .loop_mode    (loop_mode),
    .abort        (abort),
    .body_valid   (body_valid),
    .body_idx     (body_idx),
    .body_ready   (body_ready),
    .body_result  (body_result),
    .jmp_break    (jmp_break),
    .jmp_continue (jmp_continue),
    .jmp_disable  (jmp_disable),
    .busy         (busy),
    .done         (done),
    .exit_code    (exit_code),
    .iter_count   (iter_count),
    .acc          (acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_loop(input logic [IDX_W-1:0] cnt, input logic [1:0] mode);
    start      = 1'b1;
    loop_count = cnt;
    loop_mode  = mode;
    step();
    start      = 1'b0;
  endtask

  task automatic check_done(input string tag, input logic [31:0] exp_acc,
                            input logic [31:0] exp_iter, input logic [31:0] exp_exit);
    check({tag, "_done"},  done,       1);
    check({tag, "_valid"}, body_valid, 0);
    check({tag, "_busy"},  busy,       1);
    check({tag, "_acc"},   acc,        exp_acc);
    check({tag, "_iter"},  iter_count, exp_iter);
    check({tag, "_exit"},  exit_code,  exp_exit);
  endtask

  logic [DATA_W-1:0] slow_res [3];

  initial begin
    rst = 1'b1; start = 1'b0; loop_count = '0; loop_mode = '0; abort = 1'b0;
    body_ready = 1'b0; body_result = '0;
    jmp_break = 1'b0; jmp_continue = 1'b0; jmp_disable = 1'b0;
    slow_res[0] = 32'd10; slow_res[1] = 32'd20; slow_res[2] = 32'd40;
    step(); step();
    rst = 1'b0;

    // Reset state.
    check("rst_valid", body_valid, 0);
    check("rst_idx",   body_idx,   0);
    check("rst_busy",  busy,       0);
    check("rst_done",  done,       0);
    check("rst_exit",  exit_code,  0);
    check("rst_iter",  iter_count, 0);
    check("rst_acc",   acc,        0);

    // count=4, results 1..4, no jumps: 4 valid cycles then done.
    body_ready = 1'b1;
    start_loop(8'd4, 2'd0);
    for (int i = 0; i < 4; i++) begin
      body_result = 32'(i + 1);
      check("t1_valid", body_valid, 1);
      check("t1_idx",   body_idx,   32'(i));
      check("t1_iterc", iter_count, 32'(i));
      step();
    end
    check_done("t1", 32'd10, 32'd4, 32'd0);
    step();
    check("t1_idle_busy", busy, 0);
    check("t1_hold_acc",  acc,  32'd10);

    // count=8, results 5, break on idx 3.
    start_loop(8'd8, 2'd0);
    body_result = 32'd5;
    for (int i = 0; i < 4; i++) begin
      jmp_break = (i == 3);
      check("t2_idx", body_idx, 32'(i));
      step();
    end
    jmp_break = 1'b0;
    check_done("t2", 32'd15, 32'd4, 32'd1);
    step();

    // count=5, results 2, continue on idx 1 and 3.
    start_loop(8'd5, 2'd1);
    body_result = 32'd2;
    for (int i = 0; i < 5; i++) begin
      jmp_continue = (i == 1) || (i == 3);
      check("t3_idx", body_idx, 32'(i));
      step();
    end
    jmp_continue = 1'b0;
    check_done("t3", 32'd6, 32'd5, 32'd0);
    step();

    // Empty loop (mode 0), reserved mode 3, and do-while with count 0.
    start_loop(8'd0, 2'd0);
    check_done("t4a", 32'd0, 32'd0, 32'd3);
    step();
    start_loop(8'd0, 2'd3);
    check_done("t4b", 32'd0, 32'd0, 32'd3);
    step();
    start_loop(8'd0, 2'd2);
    check("t4c_valid", body_valid, 1);
    check("t4c_idx",   body_idx,   0);
    body_result = 32'd7;
    step();
    check_done("t4c", 32'd7, 32'd1, 32'd0);
    step();

    // count=6, ready every 3rd cycle, stray break flags outside handshakes,
    // abort on the idx-2 handshake.
    start_loop(8'd6, 2'd0);
    for (int c = 0; c < 9; c++) begin
      body_ready  = (c % 3 == 2);
      jmp_break   = (c % 3 != 2);
      body_result = slow_res[c / 3];
      abort       = (c == 8);
      check("t5_idx", body_idx, 32'(c / 3));
      step();
    end
    body_ready = 1'b1; jmp_break = 1'b0; abort = 1'b0;
    check_done("t5", 32'd30, 32'd2, 32'd2);
    // start during DONE is ignored.
    start = 1'b1; loop_count = 8'd3;
    step();
    start = 1'b0;
    check("t5_no_restart", busy, 0);
    // abort in IDLE is ignored.
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_idle_busy", busy,      0);
    check("t5_abort_idle_exit", exit_code, 32'd2);

    // disable together with break on idx 0: disable wins.
    start_loop(8'd3, 2'd0);
    body_result = 32'd9; jmp_disable = 1'b1; jmp_break = 1'b1;
    step();
    jmp_disable = 1'b0; jmp_break = 1'b0;
    check_done("t6", 32'd0, 32'd1, 32'd2);
    step();

    // Reset mid-loop at idx 3, then a fresh loop with accumulator wrap.
    start_loop(8'd8, 2'd0);
    body_result = 32'd1;
    step(); step(); step();
    check("t7_pre_idx", body_idx, 32'd3);
    check("t7_pre_acc", acc,      32'd3);
    rst = 1'b1;
    step();
    check("t7_rst_valid", body_valid, 0);
    check("t7_rst_idx",   body_idx,   0);
    check("t7_rst_busy",  busy,       0);
    check("t7_rst_done",  done,       0);
    check("t7_rst_exit",  exit_code,  0);
    check("t7_rst_iter",  iter_count, 0);
    check("t7_rst_acc",   acc,        0);
    rst = 1'b0;
    step();
    check("t7_no_done", done, 0);
    start_loop(8'd2, 2'd0);
    check("t7_new_idx", body_idx, 0);
    body_result = 32'hFFFF_FFFF;
    step();
    check("t7_new_idx1", body_idx, 1);
    body_result = 32'd2;
    step();
    check_done("t7", 32'd1, 32'd2, 32'd0);
    step();
    check("t7_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
